regfile_dump_unit: RTL and testbench
====================================

// Module: regfile_dump_unit
// PURPOSE
//  Debug-side master for the MIPS register file's read/write port.
//  On command, it walks every register and streams {addr,data} out over valid/ready.
//  With the load option, it also fills every register from an input stream.
//  Sits beside register_file at top level; asserts busy so the core stalls while it owns the port.
// PARAMETERS
//  NREGS   32  number of registers walked (addresses 0..NREGS-1)
//  ADDR_W  5   register address width, $clog2(NREGS)
//  DATA_W  32  register data width
// PORTS
//  clk           in   1       core clock; all logic on posedge
//  rst           in   1       synchronous, active-high reset
//  start         in   1       begin operation; sampled only in IDLE
//  load          in   1       sampled with start: 0=dump, 1=load (load needs REGDUMP_LOAD_EN)
//  busy          out  1       high in every state except IDLE
//  done          out  1       one-cycle pulse at end of operation
//  rf_readReg    out  ADDR_W  to register file readReg1
//  rf_readData   in   DATA_W  from register file readData1 (combinational read)
//  rf_regWrite   out  1       to register file regWrite
//  rf_writeReg   out  ADDR_W  to register file writeReg
//  rf_writeData  out  DATA_W  to register file writeData
//  out_valid     out  1       dump word available
//  out_ready     in   1       sink accepts dump word
//  out_addr      out  ADDR_W  register index of out_data
//  out_data      out  DATA_W  register contents
//  out_last      out  1       high with the word for index NREGS-1
//  in_valid      in   1       load word available (REGDUMP_LOAD_EN only)
//  in_ready      out  1       unit accepts load word (REGDUMP_LOAD_EN only)
//  in_data       in   DATA_W  load word (REGDUMP_LOAD_EN only)
// BEHAVIOUR
//  Reset:
//   - All outputs are 0. State=IDLE. idx=0.
//   - Reset mid-operation aborts immediately: no partial write, no done pulse.
//  FSM states: IDLE, RD, SEND, LOAD, DONE.
//  IDLE:
//   - start=1 & load=0 -> RD, idx=0.
//   - start=1 & load=1 -> LOAD, idx=0 (with macro); otherwise treated as dump.
//  RD:
//   - rf_readReg=idx.
//   - Next edge: out_data<=rf_readData, out_addr<=idx, out_valid<=1, out_last<=(idx==NREGS-1); -> SEND.
//  SEND:
//   - out_valid/out_addr/out_data/out_last stay stable until out_ready=1.
//   - On handshake: out_valid<=0. If last -> DONE, else idx++ -> RD.
//   - Rate: at most one word per 2 cycles. First out_valid is 2 cycles after start.
//  DONE: done=1 for one cycle -> IDLE.
//  Start behaviour:
//   - start while busy is ignored.
//   - start in the DONE cycle is ignored.
//  rf_readReg holds idx in every state (0 in IDLE).
//  rf_regWrite=0 in every state except LOAD.
//  idx never wraps: the operation ends at NREGS-1.
// CONFIGURATION
//  REGDUMP_LOAD_EN defined:
//   - LOAD state has in_ready=1.
//   - On in_valid&in_ready, in the same cycle: rf_regWrite=1, rf_writeReg=idx, rf_writeData=in_data.
//   - After the write at idx NREGS-1 -> DONE; otherwise idx++.
//   - Register 0 is written like any other register.
//  REGDUMP_LOAD_EN undefined:
//   - in_* ports are absent.
//   - The load input is ignored.
//   - rf_regWrite, rf_writeReg and rf_writeData are tied to 0.
// STRUCTURE
//  Package regfile_dbg_pkg holds:
//   - State enum typedef (dump_state_t).
//   - Constants NREGS_DEF=32, ADDR_W_DEF=5, DATA_W_DEF=32.
//  No sub-module: a single FSM plus idx counter and output register.
// TESTING
//  1. Reset, then start dump with out_ready=1:
//     - 32 words, out_addr k carries data k (register file reset content).
//     - out_last only at k=31; done pulses once; busy falls the next cycle.
//  2. Backpressure: out_ready low 5 cycles on word 7:
//     - out_valid, out_addr=7 and out_data hold stable; no word lost or duplicated.
//  3. start pulses during the dump at words 3 and 20:
//     - Ignored; exactly 32 words and a single done.
//  4. rst asserted while in SEND at idx 10:
//     - Next cycle: out_valid=0, busy=0, idx=0.
//     - A fresh start restarts from addr 0.
//  5. (REGDUMP_LOAD_EN) load 32 words 0xA5A5_0000+k with in_valid gaps, then dump:
//     - The dump returns 0xA5A5_0000+k at addr k.
//  6. (REGDUMP_LOAD_EN undefined) start with load=1:
//     - Behaves as a dump; rf_regWrite never asserted.

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// Shared types and default sizes for the register-file debug dump/load unit.
// Holds the FSM state encoding and the default NREGS/ADDR_W/DATA_W values.
package regfile_dbg_pkg;

  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_SEND = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_unit.sv
// Debug master for the register file port: walks every register and streams
// {addr,data} out over valid/ready, or (REGDUMP_LOAD_EN) fills every register
// from an input stream. busy stalls the core while the unit owns the port.
// Ports: clk, rst (sync, active-high); start/load command; busy, done status;
//   rf_readReg/rf_readData read port; rf_regWrite/rf_writeReg/rf_writeData
//   write port; out_valid/out_ready/out_addr/out_data/out_last dump stream;
//   in_valid/in_ready/in_data load stream (only with REGDUMP_LOAD_EN defined).
module regfile_dump_unit
  import regfile_dbg_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_readReg,
  input  logic [DATA_W-1:0] rf_readData,
  output logic              rf_regWrite,
  output logic [ADDR_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0] rf_writeData,
`ifdef REGDUMP_LOAD_EN
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic is_last;
  logic load_req;
  logic wr_fire;

  assign is_last = (idx_q == LAST_IDX);

`ifdef REGDUMP_LOAD_EN
  assign load_req     = load;
  assign in_ready     = (state_q == ST_LOAD);
  assign wr_fire      = (state_q == ST_LOAD) && in_valid;
  assign rf_writeReg  = wr_fire ? idx_q : '0;
  assign rf_writeData = wr_fire ? in_data : '0;
`else
  // Without the load path a load request simply runs a dump.
  logic unused_load;
  assign unused_load  = load;
  assign load_req     = 1'b0;
  assign wr_fire      = 1'b0;
  assign rf_writeReg  = '0;
  assign rf_writeData = '0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = load_req ? ST_LOAD : ST_RD;
        end
      end
      ST_RD: begin
        out_data_d  = rf_readData;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        out_last_d  = is_last;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = ST_RD;
          end
        end
      end
      ST_LOAD: begin
        if (wr_fire) begin
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      ST_DONE: begin
        // idx returns to 0 so the read port idles at register 0.
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d       = '0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign rf_readReg  = idx_q;
  assign rf_regWrite = wr_fire;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Scoreboard bench for regfile_dump_unit with a behavioural register file.
// Define REGDUMP_LOAD_EN for both files to exercise the load path.
module tb_regfile_dump_unit;

  logic        clk = 1'b0;
  logic        rst, start, load, out_ready;
  logic        busy, done, rf_regWrite;
  logic [4:0]  rf_readReg, rf_writeReg, out_addr;
  logic [31:0] rf_readData, rf_writeData, out_data;
  logic        out_valid, out_last;
`ifdef REGDUMP_LOAD_EN
  logic        in_valid, in_ready;
  logic [31:0] in_data;
`endif

  always #5 clk = ~clk;

  regfile_dump_unit dut (
    .clk(clk), .rst(rst), .start(start), .load(load),
    .busy(busy), .done(done),
    .rf_readReg(rf_readReg), .rf_readData(rf_readData),
    .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg),
    .rf_writeData(rf_writeData),
`ifdef REGDUMP_LOAD_EN
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  // Register file model: reset content is register k = k.
  logic [31:0] rf_mem [32];
  logic        rf_init;
  assign rf_readData = rf_mem[rf_readReg];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= 32'(k);
    end else if (rf_regWrite) begin
      rf_mem[rf_writeReg] <= rf_writeData;
    end
  end

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } word_t;

  word_t exp_q [$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int wr_seen = 0;
  int stall_seen = 0;
  int stall_addr = -1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_dump(input bit loaded, input int n);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.a = 5'(k);
      w.d = loaded ? 32'hA5A5_0000 + 32'(k) : 32'(k);
      w.l = (k == 31);
      exp_q.push_back(w);
    end
  endtask

  // Monitor: pops and compares on every accepted word.
  logic        hold_v = 1'b0;
  logic [4:0]  hold_a;
  logic [31:0] hold_d;
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (done) done_seen++;
      if (rf_regWrite) wr_seen++;
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_addr", 64'(out_addr), 64'(hold_a));
        chk("hold_data", 64'(out_data), 64'(hold_d));
      end
      hold_v = out_valid && !out_ready;
      hold_a = out_addr;
      hold_d = out_data;
      if (hold_v) stall_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got addr %0d, none expected",
                   out_addr);
        end else begin
          w = exp_q.pop_front();
          chk("word_addr", 64'(out_addr), 64'(w.a));
          chk("word_data", 64'(out_data), 64'(w.d));
          chk("word_last", 64'(out_last), 64'(w.l));
        end
      end
    end
  end

  // Sink: ready high except a 5-cycle stall on word stall_addr.
  initial begin
    int  cnt;
    bit  used;
    cnt = 0;
    used = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_addr < 0) used = 1'b0;
      if (cnt > 0) begin
        out_ready = 1'b0;
        cnt--;
      end else if (stall_addr >= 0 && !used && out_valid &&
                   int'(out_addr) == stall_addr) begin
        used = 1'b1;
        out_ready = 1'b0;
        cnt = 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic run_op(input bit ld, input bit pulse, input bit poke);
    int cyc;
    bit fin, p3, p20;
    int d0;
    d0 = done_seen;
    fin = 1'b0;
    p3 = 1'b0;
    p20 = 1'b0;
    cyc = 0;
    start = 1'b1;
    load = ld;
    @(posedge clk);
    #1;
    start = 1'b0;
    load = 1'b0;
    while (!fin && cyc < 600) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        start = 1'b0;
        if (pulse && out_valid && out_addr == 5'd3 && !p3) begin
          start = 1'b1;
          p3 = 1'b1;
        end
        if (pulse && out_valid && out_addr == 5'd20 && !p20) begin
          start = 1'b1;
          p20 = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL op_timeout: got no done, required done in 600");
    end
    start = poke;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_seen - d0), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, d0, w0, s0;
    rst = 1'b1;
    rf_init = 1'b1;
    start = 1'b0;
    load = 1'b0;
`ifdef REGDUMP_LOAD_EN
    in_valid = 1'b0;
    in_data = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_readreg", 64'(rf_readReg), 64'd0);
    chk("rst_regwrite", 64'(rf_regWrite), 64'd0);
    chk("rst_writereg", 64'(rf_writeReg), 64'd0);
    chk("rst_writedata", 64'(rf_writeData), 64'd0);
    rst = 1'b0;
    rf_init = 1'b0;
    @(posedge clk);
    #1;

    // Plain dump, plus a start poked during the DONE cycle.
    push_dump(1'b0, 32);
    run_op(1'b0, 1'b0, 1'b1);

    // Backpressure on word 7.
    s0 = stall_seen;
    stall_addr = 7;
    push_dump(1'b0, 32);
    run_op(1'b0, 1'b0, 1'b0);
    chk("stall_cycles", 64'(stall_seen - s0), 64'd5);
    stall_addr = -1;

    // Start pulses during the dump are ignored.
    push_dump(1'b0, 32);
    run_op(1'b0, 1'b1, 1'b0);

    // Reset while presenting word 10.
    d0 = done_seen;
    push_dump(1'b0, 10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_addr == 5'd10) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reach_word10", 64'(out_addr), 64'd10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_idx", 64'(rf_readReg), 64'd0);
    chk("abort_queue", 64'(exp_q.size()), 64'd0);
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);
    push_dump(1'b0, 32);
    run_op(1'b0, 1'b0, 1'b0);

`ifdef REGDUMP_LOAD_EN
    begin
      int k;
      bit hs;
      w0 = wr_seen;
      k = 0;
      cyc = 0;
      start = 1'b1;
      load = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      load = 1'b0;
      while (k < 32 && cyc < 500) begin
        in_valid = (cyc % 4 != 1);
        in_data = 32'hA5A5_0000 + 32'(k);
        @(negedge clk);
        if (in_valid) begin
          chk("load_ready", 64'(in_ready), 64'd1);
          chk("load_wr_en", 64'(rf_regWrite), 64'd1);
          chk("load_wr_reg", 64'(rf_writeReg), 64'(k));
          chk("load_wr_data", 64'(rf_writeData),
              64'(32'hA5A5_0000 + 32'(k)));
        end else begin
          chk("load_gap_wr", 64'(rf_regWrite), 64'd0);
        end
        hs = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (hs) k++;
        cyc++;
      end
      in_valid = 1'b0;
      chk("load_count", 64'(k), 64'd32);
      chk("load_done", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      chk("load_idle", 64'(busy), 64'd0);
      chk("load_writes", 64'(wr_seen - w0), 64'd32);
      push_dump(1'b1, 32);
      run_op(1'b0, 1'b0, 1'b0);
    end
`else
    w0 = wr_seen;
    push_dump(1'b0, 32);
    run_op(1'b1, 1'b0, 1'b0);
    chk("noload_writes", 64'(wr_seen - w0), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
